// File: rtl/rf_wb_queue.sv
// In-order writeback queue feeding the register file write port, with a
// per-register pending-write scoreboard for decode stall logic.
module rf_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             in_reg,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         drain_en,
  input  logic                         flush,
  output logic                         writeEn,
  output logic [SEL_W-1:0]             writeRegSel,
  output logic [DATA_W-1:0]            writeData,
  output logic [(2**SEL_W)-1:0]        busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NREG  = 2 ** SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [NREG-1:0]    busy_c;
  logic               push;
  logic               pop;
  logic               not_empty;
  entry_t             head_entry;

  assign not_empty = (count_q != '0);
  assign in_ready  = rst & (count_q < CNT_W'(DEPTH));
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = writeEn;
  assign writeEn   = rst & drain_en & not_empty & ~flush;

  assign head_entry  = mem_q[head_q];
  assign writeRegSel = not_empty ? head_entry.sel  : '0;
  assign writeData   = not_empty ? head_entry.data : '0;
  assign count       = count_q;

  // Pending-write scoreboard over all live entries
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) busy_c[mem_q[i].sel] = 1'b1;
    end
  end

  assign busy = rst ? busy_c : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        mem_d[tail_q]   = '{sel: in_reg, data: in_data};
        tail_d          = tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; synchronous active-low reset discards every entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is never cleared; validity alone gates its use
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
